// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives an external ALU from a valid/ready request stream, adds shift-add multiply (opcode 0xA)
module alu_op_sequencer #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_cmd,
  input  logic [BUS_WIDTH-1:0] req_a,
  input  logic [BUS_WIDTH-1:0] req_b,
  output logic [BUS_WIDTH-1:0] alu_a,
  output logic [BUS_WIDTH-1:0] alu_b,
  output logic [3:0]           alu_command,
  input  logic [BUS_WIDTH-1:0] alu_out,
  input  logic                 alu_overflow,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BUS_WIDTH-1:0] rsp_data,
  output logic                 rsp_flag,
  output logic                 rsp_err
);
  localparam int CW = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, MUL, RESP} state_t;
  state_t                 r_state, w_next;
  logic [3:0]             r_cmd;
  logic [BUS_WIDTH-1:0]   r_a, r_b, r_acc, r_rsp_data;
  logic                   r_lost, r_sticky, r_rsp_flag, r_rsp_err;
  logic [CW-1:0]          r_cnt;
  logic                   w_fire, w_alu_op, w_mul_op, w_mul_last, w_sticky_nxt;
  assign w_fire       = req_valid & req_ready;
  assign w_alu_op     = req_cmd <= 4'd9;
  assign w_mul_op     = req_cmd == 4'hA;
  assign w_mul_last   = r_cnt == CW'(BUS_WIDTH - 1);
  // a partial product that overflows the adder or includes already-shifted-out multiplicand bits
  assign w_sticky_nxt = r_sticky | (r_b[0] & (alu_overflow | r_lost));
  assign rsp_data     = r_rsp_data;
  assign rsp_flag     = r_rsp_flag;
  assign rsp_err      = r_rsp_err;
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_next;
  always_comb
    w_next = (r_state == IDLE)  ? (!w_fire ? IDLE : w_alu_op ? ISSUE : w_mul_op ? MUL : RESP) :
             (r_state == ISSUE) ? RESP :
             (r_state == MUL)   ? (w_mul_last ? RESP : MUL) :
                                  (rsp_ready ? IDLE : RESP);
  always_comb begin
    req_ready   = r_state == IDLE;
    rsp_valid   = r_state == RESP;
    alu_command = (r_state == ISSUE) ? r_cmd : (r_state == MUL) ? 4'h0 : 4'hF;
    alu_a       = (r_state == ISSUE) ? r_a : (r_state == MUL) ? r_acc : '0;
    alu_b       = (r_state == ISSUE) ? r_b : (r_state == MUL && r_b[0]) ? r_a : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_lost     <= 1'b0;
      r_sticky   <= 1'b0;
      r_cnt      <= '0;
      r_rsp_data <= '0;
      r_rsp_flag <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else if (w_fire) begin
      r_cmd    <= req_cmd;
      r_a      <= req_a;
      r_b      <= req_b;
      r_acc    <= '0;
      r_lost   <= 1'b0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
      if (!w_alu_op && !w_mul_op) begin
        r_rsp_data <= '0;
        r_rsp_flag <= 1'b0;
        r_rsp_err  <= 1'b1;
      end
    end else if (r_state == ISSUE) begin
      r_rsp_data <= (r_cmd <= 4'd6) ? alu_out : '0;
      r_rsp_flag <= (r_cmd == 4'd0 || r_cmd >= 4'd7) ? alu_overflow : 1'b0;
      r_rsp_err  <= 1'b0;
    end else if (r_state == MUL) begin
      r_acc    <= alu_out;
      r_sticky <= w_sticky_nxt;
      r_lost   <= r_lost | r_a[BUS_WIDTH-1];
      r_a      <= r_a << 1;
      r_b      <= r_b >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (w_mul_last) begin
        r_rsp_data <= alu_out;
        r_rsp_flag <= w_sticky_nxt;
        r_rsp_err  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: random + directed scoreboard bench with a behavioural ALU and result model
module tb_alu_op_sequencer;
  localparam int W = 8;
  logic         clk = 1'b0, reset = 1'b1;
  logic         req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0;
  logic [3:0]   req_cmd = '0, alu_command;
  logic [W-1:0] req_a = '0, req_b = '0, alu_a, alu_b, alu_out, rsp_data;
  logic         alu_overflow, rsp_flag, rsp_err;
  logic         hold = 1'b0;
  int           cyc = 0, total = 0, bad = 0;
  typedef struct {logic [W-1:0] d; logic f; logic e; int due;} exp_t;
  exp_t q[$];

  alu_op_sequencer #(.BUS_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_command(alu_command),
    .alu_out(alu_out), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flag(rsp_flag), .rsp_err(rsp_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU stand-in: {overflow, out}; compares report through overflow with out=0
  function automatic logic [W:0] alu_fn(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    case (c)
      4'd0: return {1'b0, a} + {1'b0, b};
      4'd1: return {a < b, a - b};
      4'd2: return {1'b0, a & b};
      4'd3: return {1'b0, a | b};
      4'd4: return {1'b0, a ^ b};
      4'd5: return {1'b0, a << 1};
      4'd6: return {1'b0, ~a};
      4'd7: return {a == b, {W{1'b0}}};
      4'd8: return {a > b, {W{1'b0}}};
      4'd9: return {a < b, {W{1'b0}}};
      default: return '0;
    endcase
  endfunction
  always_comb {alu_overflow, alu_out} = alu_fn(alu_command, alu_a, alu_b);

  function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b, input int now);
    exp_t e;
    logic [W:0] r;
    int p;
    e.e = 1'b0;
    if (c <= 4'd9) begin
      r = alu_fn(c, a, b);
      e.d = (c <= 4'd6) ? r[W-1:0] : '0;
      e.f = (c == 4'd0 || c >= 4'd7) ? r[W] : 1'b0;
      e.due = now + 2;
    end else if (c == 4'hA) begin
      p = int'(a) * int'(b);
      e.d = W'(p);
      e.f = p >= (1 << W);
      e.due = now + W + 1;
    end else begin
      e.d = '0;
      e.f = 1'b0;
      e.e = 1'b1;
      e.due = now + 1;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    bit done = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_cmd = c;
    req_a = a;
    req_b = b;
    for (int i = 0; i < 200 && !done; i++) begin
      if (req_ready) begin
        q.push_back(model(c, a, b, cyc));
        done = 1;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    if (!done) chk("issue_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() > 0; i++) @(negedge clk);
    chk("drain_timeout", q.size(), 0);
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // monitor: latency on first valid, stability while stalled, payload on handshake
  bit           seen = 0;
  logic [W+1:0] held;
  always @(negedge clk) begin
    if (reset) seen = 0;
    else begin
      if (rsp_valid || req_ready) chk("alu_idle", {alu_command, alu_a, alu_b}, {4'hF, {2*W{1'b0}}});
      if (rsp_valid) begin
        chk("req_ready_in_resp", req_ready, 0);
        if (q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else begin
          if (!seen) begin
            seen = 1;
            held = {rsp_data, rsp_flag, rsp_err};
            chk("latency", cyc, q[0].due);
          end else chk("rsp_stable", {rsp_data, rsp_flag, rsp_err}, held);
          if (rsp_ready) begin
            chk("rsp_data", rsp_data, q[0].d);
            chk("rsp_flag", rsp_flag, q[0].f);
            chk("rsp_err", rsp_err, q[0].e);
            void'(q.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp", {rsp_data, rsp_flag, rsp_err}, 0);
    chk("rst_alu", {alu_command, alu_a, alu_b}, {4'hF, {2*W{1'b0}}});
    reset = 1'b0;
    issue(4'd0, 8'd200, 8'd100);
    issue(4'd1, 8'd5, 8'd7);
    issue(4'd8, 8'd9, 8'd3);
    issue(4'hA, 8'd15, 8'd17);
    issue(4'hA, 8'd16, 8'd16);
    issue(4'hA, 8'd0, 8'd255);
    issue(4'hA, 8'd255, 8'd255);
    issue(4'hC, 8'd12, 8'd34);
    drain();
    hold = 1'b1;
    issue(4'd4, 8'hA5, 8'h3C);
    repeat (3) @(negedge clk);
    req_valid = 1'b1;
    req_cmd = 4'd2;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    hold = 1'b0;
    drain();
    issue(4'hA, 8'd7, 8'd9);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_req_ready", req_ready, 1);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    repeat (12) @(negedge clk);
    issue(4'hA, 8'd3, 8'd3);
    drain();
    for (int i = 0; i < 60; i++) begin
      issue(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
